// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display path: digit count, segment bit order and the
// hex glyph table used by both the encoder and the scan decoder.
package seven_seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned NUM_SEGS   = 7;
  localparam int unsigned NUM_GLYPHS = 16;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Active-high gfedcba patterns for 0..F.
  localparam logic [NUM_SEGS-1:0] GLYPH_TABLE [NUM_GLYPHS] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic is_one_hot(input logic [NUM_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/seven_seg_to_bin.sv
// Combinational inverse of the glyph encoder: maps an active-high segment pattern back to a
// nibble and flags whether the pattern is a legal glyph.
module seven_seg_to_bin
  import seven_seg_pkg::*;
(
  input  logic [NUM_SEGS-1:0] i_seg,
  output logic                o_hit,
  output logic [3:0]          o_nibble
);

  always_comb begin
    o_hit    = 1'b0;
    o_nibble = '0;
    for (int unsigned g = 0; g < NUM_GLYPHS; g++) begin
      if (i_seg == GLYPH_TABLE[g]) begin
        o_hit    = 1'b1;
        o_nibble = 4'(g);
      end
    end
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Receive side of the scanned seven-segment bus: synchronizes the pins, waits for each digit to
// settle, decodes it and publishes the 32-bit value once all eight digits have been seen.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned FRAME_TIMEOUT = 2_000_000
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [NUM_SEGS-1:0]     cat_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] val_out,
  output logic                    valid_out,
  output logic                    digit_err_out,
  output logic                    timeout_out
);

  localparam int unsigned TO_W = $clog2(FRAME_TIMEOUT);
  localparam int unsigned PAT_W = NUM_DIGITS + NUM_SEGS;
  localparam logic [7:0] SETTLE_MAX = 8'(SETTLE_CYCLES);
  localparam logic [7:0] SETTLE_HIT = 8'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FRAME_TIMEOUT - 1);

  logic [NUM_SEGS-1:0]     r_cat_meta, r_cat_sync;
  logic [NUM_DIGITS-1:0]   r_an_meta, r_an_sync;
  logic [PAT_W-1:0]        r_prev;
  logic [7:0]              r_stab;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [NUM_DIGITS-1:0]   r_mask;
  logic [TO_W-1:0]         r_to;
  logic [4*NUM_DIGITS-1:0] r_val;
  logic                    r_valid, r_err, r_timeout;

  logic [NUM_SEGS-1:0]     w_seg;
  logic [NUM_DIGITS-1:0]   w_an;
  logic [PAT_W-1:0]        w_cur;
  logic                    w_match, w_sample, w_one_hot;
  logic [2:0]              w_idx;
  logic                    w_hit;
  logic [3:0]              w_nibble;
  logic                    w_accept, w_reject, w_complete, w_timeout;
  logic [4*NUM_DIGITS-1:0] w_shadow_nxt;
  logic [NUM_DIGITS-1:0]   w_mask_nxt;

  assign w_seg   = ~r_cat_sync;
  assign w_an    = ~r_an_sync;
  assign w_cur   = {w_an, w_seg};
  assign w_match = (w_cur == r_prev);
  // Fires only on the counter's SETTLE_CYCLES-1 -> SETTLE_CYCLES step, once per stable period.
  assign w_sample  = w_match && (r_stab == SETTLE_HIT);
  assign w_one_hot = is_one_hot(w_an);

  always_comb begin
    w_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (w_an[i]) w_idx = 3'(i);
    end
  end

  seven_seg_to_bin u_to_bin (
    .i_seg    (w_seg),
    .o_hit    (w_hit),
    .o_nibble (w_nibble)
  );

  assign w_accept = w_sample && w_one_hot && w_hit;
  assign w_reject = w_sample && (w_an != '0) && !(w_one_hot && w_hit);

  always_comb begin
    w_shadow_nxt = r_shadow;
    w_mask_nxt   = r_mask;
    if (w_accept) begin
      w_shadow_nxt[{w_idx, 2'b00} +: 4] = w_nibble;
      w_mask_nxt[w_idx]                 = 1'b1;
    end
  end

  assign w_complete = w_accept && (w_mask_nxt == '1);
  assign w_timeout  = !w_complete && (r_to == TO_LAST);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cat_meta <= '0;
      r_cat_sync <= '0;
      r_an_meta  <= '0;
      r_an_sync  <= '0;
      r_prev     <= '0;
      r_stab     <= '0;
      r_shadow   <= '0;
      r_mask     <= '0;
      r_to       <= '0;
      r_val      <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_cat_meta <= cat_in;
      r_cat_sync <= r_cat_meta;
      r_an_meta  <= an_in;
      r_an_sync  <= r_an_meta;
      r_prev     <= w_cur;

      if (!w_match)                 r_stab <= '0;
      else if (r_stab != SETTLE_MAX) r_stab <= r_stab + 8'd1;

      r_shadow <= w_shadow_nxt;
      r_mask   <= (w_complete || w_timeout) ? '0 : w_mask_nxt;

      if (w_complete || w_timeout) r_to <= '0;
      else                         r_to <= r_to + 1'b1;

      if (w_complete) r_val <= w_shadow_nxt;
      r_valid   <= w_complete;
      r_err     <= w_reject;
      r_timeout <= w_timeout;
    end
  end

  assign val_out       = r_val;
  assign valid_out     = r_valid;
  assign digit_err_out = r_err;
  assign timeout_out   = r_timeout;

endmodule

// File: doc/seven_seg_scan_decoder.md
# seven_seg_scan_decoder

Receive side of the multiplexed seven-segment display bus. Samples active-low cathode/anode lines, as driven by our display controller or an external board, and waits for each digit's pattern to settle. It decodes each settled glyph back to a hex nibble and reassembles the full 8-digit, 32-bit value once every digit has been seen. Used for loopback self-test of the display path and for capturing values from external boards that expose only a scanned display.

## Interface
- SETTLE_CYCLES, 16: consecutive cycles a synchronized {an, cat} pattern must hold unchanged before it is sampled; legal range 2..255.
- FRAME_TIMEOUT, 2_000_000: cycles without a completed frame before the partial frame is discarded; must be > SETTLE_CYCLES.
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-low.
- cat_in  input  7  cathodes, active-low; bit0=a … bit6=g.
- an_in  input  8  anodes, active-low; bit i selects digit i, which carries nibble [4i+3:4i].
- val_out  output  32  last completed frame; holds until the next frame completes.
- valid_out  output  1  one-cycle pulse when val_out updates.
- digit_err_out  output  1  one-cycle pulse on a rejected sample.
- timeout_out  output  1  one-cycle pulse when a partial frame is discarded.

## Operation
- Inputs are asynchronous pins. Both buses pass through a 2-flop synchronizer, then are inverted to active-high seg[6:0] and an[7:0].
- Stability counter:
  - Compares the current synchronized {an, seg} with the previous cycle's value.
  - On mismatch the counter goes to 0. On match it increments, saturating at SETTLE_CYCLES.
  - A sample occurs in exactly one cycle per stable period: the cycle where the counter goes from SETTLE_CYCLES-1 to SETTLE_CYCLES.
- Sample handling:
  - an == 0 (blanking): ignored, no error.
  - an not one-hot: digit_err_out pulse; shadow and mask unchanged.
  - an one-hot at index i and seg matches a glyph: nibble written to shadow[4i+3:4i], mask[i] set. A repeat sample of the same digit overwrites the nibble; latest wins.
  - an one-hot but seg matches no glyph: digit_err_out pulse; mask[i] not set.
- Frame completion:
  - When a sample makes mask == 8'hFF, val_out is loaded from shadow, including the nibble just decoded, in that same edge.
  - valid_out pulses, mask clears and the timeout counter clears.
- Timeout:
  - The counter increments every cycle and clears on frame completion.
  - On reaching FRAME_TIMEOUT-1: timeout_out pulses, mask clears and the counter restarts at 0.
  - val_out is retained.
  - If completion and timeout occur in the same cycle, completion wins: no timeout_out.
- Glyph table (hex gfedcba) for 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71. Any other pattern is invalid.

## Timing
- Reset (rst_in low, asynchronous) clears:
  - val_out = 0; valid_out = 0; digit_err_out = 0; timeout_out = 0.
  - Synchronizers, shadow, mask, stability counter and timeout counter all = 0.
  - Reset mid-frame discards partial data.
- Release of reset is synchronous to clk_in. The first sample is possible no earlier than SETTLE_CYCLES+2 edges after release.
- Latency: pins settle before edge k, and the sample registers at edge k+2+SETTLE_CYCLES. valid_out, digit_err_out and val_out are visible in the following cycle.
- Pulses are exactly one cycle wide. At most one of valid_out/digit_err_out is set per cycle.
- Patterns shorter than SETTLE_CYCLES after synchronization are never sampled. This covers ghosting during anode transitions.

## Structure
- Package seven_seg_pkg holds:
  - NUM_DIGITS = 8.
  - The 16-entry glyph table, also the reference for the encoder side.
  - Segment bit-order constants.
- Sub-module seven_seg_to_bin: combinational seg[6:0] → {hit, nibble[3:0]} lookup against the package table, the inverse of bin_to_seven_seg.
- The top level holds the synchronizers, stability counter, shadow/mask, timeout counter and output registers.

## Test plan
Bench parameters: SETTLE_CYCLES=4, FRAME_TIMEOUT=1000.
- Scan of 0xDEADBEEF, digits 0..7 each held 20 cycles with 2 blank cycles between -> val_out=0xDEADBEEF, valid_out one pulse per 8-digit pass, digit_err_out never set.
- Digit 3 pattern held only 3 cycles, others normal -> no valid_out that pass; the next full pass yields a correct value.
- Digit 2 cat_in=~7'h49 held 20 cycles -> one digit_err_out pulse, mask[2] clear; the frame completes only after digit 2 is shown validly.
- an_in=~8'b0000_0011 held 20 cycles -> one digit_err_out pulse, shadow unchanged.
- Digits 0..4 shown, then bus idle -> timeout_out pulses 1000 cycles after reset/last frame, val_out unchanged; a subsequent full scan of 0x12345678 completes normally.
- rst_in pulled low asynchronously mid-frame after a prior valid frame -> all outputs 0 immediately; after release a full scan of 0x0000000F yields val_out=0x0000000F.
